// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, the idle opcode that parks the ALU,
// and the sequencer state encoding used by alu_arbiter.
`timescale 1ns/1ps
package alu_pkg;

  localparam int NB_OP = 6;

  localparam logic [NB_OP-1:0] OP_SLL  = 6'b000000;
  localparam logic [NB_OP-1:0] OP_SRL  = 6'b000010;
  localparam logic [NB_OP-1:0] OP_SRA  = 6'b000011;
  localparam logic [NB_OP-1:0] OP_ADD  = 6'b100000;
  localparam logic [NB_OP-1:0] OP_SUB  = 6'b100010;
  localparam logic [NB_OP-1:0] OP_AND  = 6'b100100;
  localparam logic [NB_OP-1:0] OP_OR   = 6'b100101;
  localparam logic [NB_OP-1:0] OP_XOR  = 6'b100110;
  localparam logic [NB_OP-1:0] OP_NOR  = 6'b100111;
  localparam logic [NB_OP-1:0] OP_SLT  = 6'b101010;
  localparam logic [NB_OP-1:0] OP_SLTU = 6'b101011;

  // Undefined code: the ALU answers 0, so it is driven whenever no operation runs.
  localparam logic [NB_OP-1:0] IDLE_OP = 6'b111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick: a lone request wins outright,
// and on contention the requester opposite the last grant wins.
`timescale 1ns/1ps
module rr_arbiter2 (
  input  logic [1:0] i_request,
  input  logic       i_last_grant,
  output logic [1:0] o_grant,
  output logic       o_grant_idx
);

  always_comb begin
    if (&i_request) begin
      o_grant_idx = ~i_last_grant;
    end else begin
      o_grant_idx = i_request[1];
    end
  end

  assign o_grant = (|i_request) ? (o_grant_idx ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between the EX stage (requester 0) and the
// debug unit (requester 1): accept, one EXEC cycle, then hold the response until taken.
`timescale 1ns/1ps
module alu_arbiter #(
  parameter int NB_DATA = 32,
  parameter int NB_OP   = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [1:0]           i_req_valid,
  output logic [1:0]           o_req_ready,
  input  logic [2*NB_DATA-1:0] i_req_datoA,
  input  logic [2*NB_DATA-1:0] i_req_datoB,
  input  logic [2*NB_OP-1:0]   i_req_operation,
  input  logic [9:0]           i_req_shamt,
  output logic [1:0]           o_rsp_valid,
  input  logic [1:0]           i_rsp_ready,
  output logic [NB_DATA-1:0]   o_rsp_data,
  output logic [NB_DATA-1:0]   o_alu_datoA,
  output logic [NB_DATA-1:0]   o_alu_datoB,
  output logic [NB_OP-1:0]     o_alu_operation,
  output logic [4:0]           o_alu_shamt,
  input  logic [NB_DATA-1:0]   i_alu_data
);

  import alu_pkg::*;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_owner;
  logic                 r_last_grant;
  logic [NB_DATA-1:0]   r_datoA;
  logic [NB_DATA-1:0]   r_datoB;
  logic [NB_OP-1:0]     r_operation;
  logic [4:0]           r_shamt;
  logic [NB_DATA-1:0]   r_result;

  logic [1:0]           w_grant;
  logic                 w_grant_idx;
  logic                 w_accept;
  logic                 w_rsp_done;

  rr_arbiter2 u_rr_arbiter2 (
    .i_request    (i_req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next    = r_state;
    o_req_ready     = 2'b00;
    o_rsp_valid     = 2'b00;
    o_alu_operation = NB_OP'(IDLE_OP);
    w_accept        = 1'b0;
    w_rsp_done      = 1'b0;
    case (r_state)
      IDLE: begin
        o_req_ready = w_grant;
        if (|(i_req_valid & w_grant)) begin
          w_accept     = 1'b1;
          w_state_next = EXEC;
        end
      end
      EXEC: begin
        o_alu_operation = r_operation;
        w_state_next    = RESP;
      end
      RESP: begin
        o_rsp_valid[r_owner] = 1'b1;
        if (i_rsp_ready[r_owner]) begin
          w_rsp_done   = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand registers keep their contents after the operation so the ALU inputs stay quiet.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_datoA      <= '0;
      r_datoB      <= '0;
      r_operation  <= NB_OP'(IDLE_OP);
      r_shamt      <= '0;
      r_result     <= '0;
    end else begin
      if (w_accept) begin
        r_owner     <= w_grant_idx;
        r_datoA     <= i_req_datoA[w_grant_idx*NB_DATA +: NB_DATA];
        r_datoB     <= i_req_datoB[w_grant_idx*NB_DATA +: NB_DATA];
        r_operation <= i_req_operation[w_grant_idx*NB_OP +: NB_OP];
        r_shamt     <= i_req_shamt[w_grant_idx*5 +: 5];
      end
      if (r_state == EXEC) begin
        r_result <= i_alu_data;
      end
      if (w_rsp_done) begin
        r_last_grant <= r_owner;
      end
    end
  end

  assign o_alu_datoA = r_datoA;
  assign o_alu_datoB = r_datoB;
  assign o_alu_shamt = r_shamt;
  assign o_rsp_data  = r_result;

endmodule
